// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA stage: per byte swaps S[i]/S[j], fetches keystream f, writes f ^ rom byte to RAM.
// Latency: 9 cycles per byte; finish pulses 9*MSG_LENGTH+1 cycles after the start edge.
// No backpressure: memories are fixed 1-cycle latency; start is ignored while busy.
module prga_decrypt_fsm #(
    parameter int MSG_LENGTH = 32,
    parameter int MSG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  finish,
    output logic [7:0]            s_address,
    output logic [7:0]            s_data,
    output logic                  s_wren,
    input  logic [7:0]            s_q,
    output logic [MSG_ADDR_W-1:0] rom_address,
    input  logic [7:0]            rom_q,
    output logic [MSG_ADDR_W-1:0] ram_address,
    output logic [7:0]            ram_data,
    output logic                  ram_wren
);

    localparam logic [MSG_ADDR_W-1:0] K_LAST = MSG_ADDR_W'(MSG_LENGTH - 1);

    typedef enum logic [3:0] {
        IDLE,
        SI_ADDR,
        SI_DATA,
        SJ_ADDR,
        SJ_DATA,
        WR_I,
        WR_J,
        F_ADDR,
        F_DATA,
        WR_OUT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]            i, j, si, sj, f, enc;
    logic [MSG_ADDR_W-1:0] k;
    logic [7:0]            f_index;

    // keystream lookup index, modulo 256 by width
    assign f_index = si + sj;

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // datapath registers, updated according to the state being left
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i   <= 8'd0;
            j   <= 8'd0;
            k   <= '0;
            si  <= 8'd0;
            sj  <= 8'd0;
            f   <= 8'd0;
            enc <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i <= 8'd0;
                        j <= 8'd0;
                        k <= '0;
                    end
                end
                SI_ADDR: i <= i + 8'd1;
                SI_DATA: begin
                    si <= s_q;
                    j  <= j + s_q;
                end
                SJ_DATA: sj <= s_q;
                F_DATA: begin
                    f   <= s_q;
                    enc <= rom_q;
                end
                WR_OUT: begin
                    if (k != K_LAST) begin
                        k <= k + MSG_ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // next state and bus outputs; everything defaults to 0 so the wired-OR S bus stays clean
    always_comb begin
        state_nxt   = state;
        finish      = 1'b0;
        s_address   = 8'd0;
        s_data      = 8'd0;
        s_wren      = 1'b0;
        rom_address = '0;
        ram_address = '0;
        ram_data    = 8'd0;
        ram_wren    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SI_ADDR;
                end
            end
            SI_ADDR: begin
                s_address = i + 8'd1;
                state_nxt = SI_DATA;
            end
            SI_DATA: begin
                // i already advanced, so this holds the address presented last cycle
                s_address = i;
                state_nxt = SJ_ADDR;
            end
            SJ_ADDR: begin
                s_address = j;
                state_nxt = SJ_DATA;
            end
            SJ_DATA: begin
                s_address = j;
                state_nxt = WR_I;
            end
            WR_I: begin
                s_address = i;
                s_data    = sj;
                s_wren    = 1'b1;
                state_nxt = WR_J;
            end
            WR_J: begin
                // when i == j both writes hit one location with the same value
                s_address = j;
                s_data    = si;
                s_wren    = 1'b1;
                state_nxt = F_ADDR;
            end
            F_ADDR: begin
                s_address   = f_index;
                rom_address = k;
                state_nxt   = F_DATA;
            end
            F_DATA: begin
                s_address   = f_index;
                rom_address = k;
                state_nxt   = WR_OUT;
            end
            WR_OUT: begin
                ram_address = k;
                ram_data    = f ^ enc;
                ram_wren    = 1'b1;
                state_nxt   = (k == K_LAST) ? DONE : SI_ADDR;
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Bench for prga_decrypt_fsm: two instances (3-byte and 32-byte messages) with memory models.
// Expected RAM/S contents come from a plain software RC4 PRGA model.
// Runs are bounded by fixed cycle budgets; a missing finish shows up as a failed check.
module tb_prga_decrypt_fsm;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // shared initial images and model results
    logic [7:0] s_init   [256];
    logic [7:0] rom_init [32];
    logic [7:0] exp_ram  [32];
    logic [7:0] exp_s    [256];

    // ---------------- 3-byte instance ----------------
    logic       rst3 = 1'b1, start3 = 1'b0, load3 = 1'b0;
    logic       finish3, s_wren3, ram_wren3;
    logic [7:0] s_address3, s_data3, s_q3, rom_q3, ram_data3;
    logic [4:0] rom_address3, ram_address3;
    logic [7:0] s_mem3 [256];
    logic [7:0] rom3   [32];
    logic [7:0] ram3   [32];

    prga_decrypt_fsm #(.MSG_LENGTH(3), .MSG_ADDR_W(5)) u_dut3 (
        .clock(clock), .reset(rst3), .start(start3), .finish(finish3),
        .s_address(s_address3), .s_data(s_data3), .s_wren(s_wren3), .s_q(s_q3),
        .rom_address(rom_address3), .rom_q(rom_q3),
        .ram_address(ram_address3), .ram_data(ram_data3), .ram_wren(ram_wren3)
    );

    always @(posedge clock) begin
        if (load3) begin
            for (int a = 0; a < 256; a++) s_mem3[a] <= s_init[a];
            for (int a = 0; a < 32; a++) begin
                rom3[a] <= rom_init[a];
                ram3[a] <= 8'h00;
            end
        end else begin
            s_q3   <= s_mem3[s_address3];
            rom_q3 <= rom3[rom_address3];
            if (s_wren3) s_mem3[s_address3] <= s_data3;
            if (ram_wren3) ram3[ram_address3] <= ram_data3;
        end
    end

    // ---------------- 32-byte instance ----------------
    logic       rst32 = 1'b1, start32 = 1'b0, load32 = 1'b0;
    logic       finish32, s_wren32, ram_wren32;
    logic [7:0] s_address32, s_data32, s_q32, rom_q32, ram_data32;
    logic [4:0] rom_address32, ram_address32;
    logic [7:0] s_mem32 [256];
    logic [7:0] rom32   [32];
    logic [7:0] ram32   [32];

    prga_decrypt_fsm #(.MSG_LENGTH(32), .MSG_ADDR_W(5)) u_dut32 (
        .clock(clock), .reset(rst32), .start(start32), .finish(finish32),
        .s_address(s_address32), .s_data(s_data32), .s_wren(s_wren32), .s_q(s_q32),
        .rom_address(rom_address32), .rom_q(rom_q32),
        .ram_address(ram_address32), .ram_data(ram_data32), .ram_wren(ram_wren32)
    );

    always @(posedge clock) begin
        if (load32) begin
            for (int a = 0; a < 256; a++) s_mem32[a] <= s_init[a];
            for (int a = 0; a < 32; a++) begin
                rom32[a] <= rom_init[a];
                ram32[a] <= 8'h00;
            end
        end else begin
            s_q32   <= s_mem32[s_address32];
            rom_q32 <= rom32[rom_address32];
            if (s_wren32) s_mem32[s_address32] <= s_data32;
            if (ram_wren32) ram32[ram_address32] <= ram_data32;
        end
    end

    // software RC4 PRGA over a copy of s_init
    task automatic model(input int n);
        int sm [256];
        int i, j, t;
        for (int a = 0; a < 256; a++) sm[a] = int'(s_init[a]);
        i = 0;
        j = 0;
        for (int k = 0; k < n; k++) begin
            i = (i + 1) % 256;
            j = (j + sm[i]) % 256;
            t = sm[i]; sm[i] = sm[j]; sm[j] = t;
            exp_ram[k] = 8'(sm[(sm[i] + sm[j]) % 256] ^ int'(rom_init[k]));
        end
        for (int a = 0; a < 256; a++) exp_s[a] = 8'(sm[a]);
    endtask

    task automatic set_identity();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    endtask

    // one pulse of start, then observe cycle by cycle (cycle 1 = first cycle after the start edge)
    task automatic run3(input bit disturb, output int fin_cyc, output int fin_cnt,
                        output int swren_cnt, output int ramwren_cnt, output int viol);
        fin_cyc = -1; fin_cnt = 0; swren_cnt = 0; ramwren_cnt = 0; viol = 0;
        @(negedge clock); start3 = 1'b1;
        @(negedge clock); start3 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (finish3) begin
                fin_cnt++;
                if (fin_cyc < 0) fin_cyc = c;
            end
            if (s_wren3) swren_cnt++;
            if (ram_wren3) ramwren_cnt++;
            if (!s_wren3 && s_data3 != 8'h00) viol++;
            if (!ram_wren3 && (ram_address3 != 5'd0 || ram_data3 != 8'h00)) viol++;
            if (fin_cyc >= 0 && (s_address3 != 8'h00 || s_data3 != 8'h00 || s_wren3 ||
                                 ram_wren3 || rom_address3 != 5'd0)) viol++;
            start3 = disturb && (c == 12 || c == 28);
            @(negedge clock);
        end
        start3 = 1'b0;
    endtask

    task automatic run32(output int fin_cyc, output int fin_cnt,
                         output int swren_cnt, output int ramwren_cnt, output int viol);
        fin_cyc = -1; fin_cnt = 0; swren_cnt = 0; ramwren_cnt = 0; viol = 0;
        @(negedge clock); start32 = 1'b1;
        @(negedge clock); start32 = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (finish32) begin
                fin_cnt++;
                if (fin_cyc < 0) fin_cyc = c;
            end
            if (s_wren32) swren_cnt++;
            if (ram_wren32) ramwren_cnt++;
            if (!s_wren32 && s_data32 != 8'h00) viol++;
            if (!ram_wren32 && (ram_address32 != 5'd0 || ram_data32 != 8'h00)) viol++;
            if (fin_cyc >= 0 && (s_address32 != 8'h00 || s_data32 != 8'h00 || s_wren32 ||
                                 ram_wren32 || rom_address32 != 5'd0)) viol++;
            @(negedge clock);
        end
    endtask

    task automatic load_mem3();
        @(negedge clock); load3 = 1'b1;
        @(negedge clock); load3 = 1'b0;
    endtask

    task automatic load_mem32();
        @(negedge clock); load32 = 1'b1;
        @(negedge clock); load32 = 1'b0;
    endtask

    task automatic check_ram3(input string tag);
        for (int k = 0; k < 3; k++) chk($sformatf("%s_ram%0d", tag, k), int'(ram3[k]), int'(exp_ram[k]));
    endtask

    initial begin
        int fc, fn, sw, rw, vl, bad, b;
        logic [7:0] t;
        logic [7:0] ks_zero [3];
        logic [7:0] ks_rom  [3];
        ks_zero = '{8'h02, 8'h05, 8'h07};
        ks_rom  = '{8'hFD, 8'hAF, 8'h17};

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_sbus3", int'({s_address3, s_data3, s_wren3}), 0);
        chk("rst_ctl3", int'({finish3, ram_wren3, rom_address3, ram_address3, ram_data3}), 0);
        chk("rst_sbus32", int'({s_address32, s_data32, s_wren32}), 0);
        chk("rst_ctl32", int'({finish32, ram_wren32, rom_address32, ram_address32, ram_data32}), 0);
        rst3 = 1'b0;
        rst32 = 1'b0;

        // identity S, ROM all zero
        set_identity();
        for (int a = 0; a < 32; a++) rom_init[a] = 8'h00;
        model(3);
        load_mem3();
        run3(1'b0, fc, fn, sw, rw, vl);
        check_ram3("id");
        for (int k = 0; k < 3; k++) chk($sformatf("id_const%0d", k), int'(ram3[k]), int'(ks_zero[k]));
        chk("id_s1", int'(s_mem3[1]), 1);
        chk("id_s2", int'(s_mem3[2]), 3);
        chk("id_s3", int'(s_mem3[3]), 5);
        chk("id_s5", int'(s_mem3[5]), 2);
        bad = 0;
        for (int a = 0; a < 256; a++) if (s_mem3[a] != exp_s[a]) bad++;
        chk("id_s_all", bad, 0);
        chk("id_fin_cyc", fc, 28);
        chk("id_fin_cnt", fn, 1);
        chk("id_swren", sw, 6);
        chk("id_ramwren", rw, 3);
        chk("id_bus_idle", vl, 0);

        // same S, non-zero ROM
        rom_init[0] = 8'hFF; rom_init[1] = 8'hAA; rom_init[2] = 8'h10;
        model(3);
        load_mem3();
        run3(1'b0, fc, fn, sw, rw, vl);
        check_ram3("rom");
        for (int k = 0; k < 3; k++) chk($sformatf("rom_const%0d", k), int'(ram3[k]), int'(ks_rom[k]));
        chk("rom_fin_cyc", fc, 28);

        // start re-pulsed mid-run and during DONE
        load_mem3();
        run3(1'b1, fc, fn, sw, rw, vl);
        check_ram3("dist");
        chk("dist_fin_cyc", fc, 28);
        chk("dist_fin_cnt", fn, 1);
        chk("dist_swren", sw, 6);
        chk("dist_ramwren", rw, 3);
        chk("dist_bus_idle", vl, 0);

        // reset during WR_I of byte 2 (cycle 23)
        load_mem3();
        @(negedge clock); start3 = 1'b1;
        @(negedge clock); start3 = 1'b0;
        repeat (22) @(negedge clock);
        chk("wri_wren", int'(s_wren3), 1);
        chk("wri_addr", int'(s_address3), 3);
        chk("wri_data", int'(s_data3), 5);
        rst3 = 1'b1;
        #1;
        chk("mid_rst_sbus", int'({s_address3, s_data3, s_wren3}), 0);
        chk("mid_rst_ctl", int'({finish3, ram_wren3, rom_address3, ram_address3, ram_data3}), 0);
        @(negedge clock); rst3 = 1'b0;
        set_identity();
        for (int a = 0; a < 32; a++) rom_init[a] = 8'h00;
        model(3);
        load_mem3();
        run3(1'b0, fc, fn, sw, rw, vl);
        check_ram3("rerun");
        for (int k = 0; k < 3; k++) chk($sformatf("rerun_const%0d", k), int'(ram3[k]), int'(ks_zero[k]));
        chk("rerun_fin_cyc", fc, 28);

        // 32-byte runs with random permutation S and random ROM
        for (int it = 0; it < 2; it++) begin
            set_identity();
            for (int a = 255; a > 0; a--) begin
                b = int'($urandom_range(a, 0));
                t = s_init[a]; s_init[a] = s_init[b]; s_init[b] = t;
            end
            for (int a = 0; a < 32; a++) rom_init[a] = 8'($urandom);
            model(32);
            load_mem32();
            run32(fc, fn, sw, rw, vl);
            bad = 0;
            for (int k = 0; k < 32; k++)
                chk($sformatf("rnd%0d_ram%0d", it, k), int'(ram32[k]), int'(exp_ram[k]));
            for (int a = 0; a < 256; a++) if (s_mem32[a] != exp_s[a]) bad++;
            chk($sformatf("rnd%0d_s_all", it), bad, 0);
            chk($sformatf("rnd%0d_fin_cyc", it), fc, 289);
            chk($sformatf("rnd%0d_fin_cnt", it), fn, 1);
            chk($sformatf("rnd%0d_swren", it), sw, 64);
            chk($sformatf("rnd%0d_ramwren", it), rw, 32);
            chk($sformatf("rnd%0d_bus_idle", it), vl, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
